// File: rtl/random_pkg.sv
// -----------------------------------------------------------------------------
// random_pkg
//  Shared definitions for the random-number custom instructions.
//  - state_t   : FSM state encoding used by random_range (ST_IDLE/ST_RUN/ST_DONE)
//  - RND_WIDTH : default operand/result width
// -----------------------------------------------------------------------------
package random_pkg;

   localparam int RND_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : random_pkg

// File: rtl/random_range_step.sv
// -----------------------------------------------------------------------------
// random_range_step
//  One restoring-division step: shift the next dividend bit into the partial
//  remainder, then subtract the divisor if it fits.
//  Ports:
//   rem_in   [WIDTH:0]   partial remainder before this step
//   bit_in               next dividend bit (MSB first)
//   divisor  [WIDTH-1:0] modulus
//   rem_out  [WIDTH:0]   partial remainder after this step
// -----------------------------------------------------------------------------
module random_range_step
   import random_pkg::*;
#(
   parameter int WIDTH = RND_WIDTH
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_out
);

   typedef logic [WIDTH:0] rem_t;

   // One spare bit above the remainder so the shifted value never wraps,
   // even when the divisor is close to the maximum operand value.
   logic [WIDTH+1:0] t;

   // NOTE: every output of a combinational block is assigned on all paths, so no latch is inferred.
   always_comb begin
      t = {rem_in, bit_in};
      if (t >= {2'b00, divisor}) begin
         rem_out = rem_t'(t - {2'b00, divisor});
      end else begin
         rem_out = rem_t'(t);
      end
   end

endmodule : random_range_step

// File: rtl/random_range.sv
// -----------------------------------------------------------------------------
// random_range
//  Multi-cycle Nios II custom instruction: result = dataA mod dataB, computed
//  with a bit-serial restoring divider (one dividend bit per enabled clock).
//  A zero modulus returns dataA unchanged.
//  Ports:
//   clk      system clock
//   reset    asynchronous, active-high reset
//   clk_en   custom-instruction clock enable; all state frozen when low
//   start    one-cycle request, dataA/dataB valid in the same cycle
//   dataA    dividend (raw random value)
//   dataB    modulus (range bound)
//   done     one-cycle completion pulse
//   result   dataA mod dataB, held until the next completion
// -----------------------------------------------------------------------------
module random_range
   import random_pkg::*;
#(
   parameter int WIDTH = RND_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_en,
   input  logic             start,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH);

   typedef logic [CW-1:0]    cnt_t;
   typedef logic [WIDTH-1:0] word_t;

   state_t           state;
   cnt_t             cnt;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH:0]   rem;
   logic [WIDTH:0]   rem_next;

   random_range_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem_in  (rem),
      .bit_in  (dividend[WIDTH-1]),
      .divisor (divisor),
      .rem_out (rem_next)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the operand registers are reset too; they are few and a known value keeps simulation X-free.
         state    <= ST_IDLE;
         cnt      <= '0;
         dividend <= '0;
         divisor  <= '0;
         rem      <= '0;
         done     <= 1'b0;
         result   <= '0;
      end else if (clk_en) begin
         // done is a single-enabled-cycle pulse; DONE re-asserts it below.
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               // A start that coincides with the previous done pulse is dropped.
               if (start && !done) begin
                  dividend <= dataA;
                  divisor  <= dataB;
                  rem      <= '0;
                  if (dataB == '0) begin
                     state <= ST_DONE;
                  end else begin
                     cnt   <= cnt_t'(WIDTH - 1);
                     state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               rem      <= rem_next;
               dividend <= {dividend[WIDTH-2:0], 1'b0};
               if (cnt == '0) begin
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt - cnt_t'(1);
               end
            end
            ST_DONE: begin
               // Divide-by-zero skipped RUN, so the dividend is still intact.
               result <= (divisor == '0) ? dividend : word_t'(rem);
               done   <= 1'b1;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule : random_range

// File: tb/tb_random_range.sv
// -----------------------------------------------------------------------------
// tb_random_range
//  Scoreboard bench for random_range. The driver issues operations and pushes
//  the expected remainder and completion cycle; a monitor pops and compares on
//  every fresh done pulse.
// -----------------------------------------------------------------------------
module tb_random_range;
   import random_pkg::*;

   localparam int W   = RND_WIDTH;
   localparam int TMO = 200;

   typedef struct {
      logic [W-1:0] res;
      int           cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         clk_en = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] dataA = '0;
   logic [W-1:0] dataB = '0;
   logic         done;
   logic [W-1:0] result;

   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   logic         last_en = 1'b1;
   logic [W-1:0] held_res = '0;
   exp_t         sb[$];

   random_range #(
      .WIDTH (W)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .clk_en (clk_en),
      .start  (start),
      .dataA  (dataA),
      .dataB  (dataB),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   // Cycle count and whether the most recent edge was an enabled one.
   always @(posedge clk) begin
      cyc     <= cyc + 1;
      last_en <= clk_en;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
      $fatal(1);
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain modulo, zero modulus passes the dividend through.
   function automatic logic [W-1:0] ref_mod(input logic [W-1:0] a, input logic [W-1:0] b);
      if (b == '0) return a;
      return a % b;
   endfunction

   // Enabled edges from the start-sampling edge to done visible.
   function automatic int latency(input logic [W-1:0] b);
      return (b == '0) ? 2 : W + 2;
   endfunction

   // Monitor: a done seen right after an enabled edge is a new completion;
   // a done seen after a disabled edge must be holding its value.
   always @(negedge clk) begin
      if (!reset && done) begin
         if (last_en) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 with result %h expected no completion (cyc %0d)", result, cyc);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("result", result, e.res);
               check("done_cycle", W'(cyc), W'(e.cyc));
            end
         end else begin
            check("held_result", result, held_res);
         end
         held_res = result;
      end
   end

   task automatic wait_idle();
      int t;
      t = 0;
      while (sb.size() != 0 && t < TMO) begin
         @(negedge clk);
         t++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done after %0d cycles expected %0d pending completion(s)", TMO, sb.size());
         sb.delete();
      end
   endtask

   // Issue one operation; optionally drop clk_en for stall_len cycles after
   // stall_at enabled edges (counting the start-sampling edge).
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int stall_at, input int stall_len);
      int   n;
      int   lat;
      int   cnt;
      exp_t e;
      lat = latency(b);
      @(negedge clk);
      start = 1'b1;
      dataA = a;
      dataB = b;
      n     = cyc;
      e.res = ref_mod(a, b);
      e.cyc = n + lat + ((stall_len > 0 && stall_at < lat) ? stall_len : 0);
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      cnt   = 1;
      if (stall_len > 0) begin
         while (cnt < stall_at) begin
            @(negedge clk);
            cnt++;
         end
         clk_en = 1'b0;
         repeat (stall_len) @(negedge clk);
         clk_en = 1'b1;
      end
      wait_idle();
   endtask

   initial begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           mode;
      int           s_at;
      int           s_len;
      exp_t         e;

      repeat (2) @(negedge clk);
      check("reset_done", W'(done), '0);
      check("reset_result", result, '0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_done", W'(done), '0);

      // Directed cases
      run_op(32'd100, 32'd7, 0, 0);
      run_op(32'd5, 32'd0, 0, 0);
      run_op(32'd3, 32'd10, 0, 0);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      run_op(32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
      run_op(32'd42, 32'd42, 0, 0);
      run_op(32'd1000, 32'd9, 10, 5);
      // Stall starting just as done appears: done and result must hold.
      run_op(32'd77, 32'd5, W + 2, 3);
      run_op(32'd9, 32'd0, 2, 3);

      // start while running is ignored
      @(negedge clk);
      start = 1'b1;
      dataA = 32'd100;
      dataB = 32'd7;
      e.res = 32'd2;
      e.cyc = cyc + W + 2;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      start = 1'b1;
      dataA = 32'd0;
      dataB = 32'd1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();

      // start coincident with done is ignored
      @(negedge clk);
      start = 1'b1;
      dataA = 32'd3;
      dataB = 32'd10;
      e.res = 32'd3;
      e.cyc = cyc + W + 2;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      begin
         int t;
         t = 0;
         while (!done && t < TMO) begin
            @(negedge clk);
            t++;
         end
      end
      start = 1'b1;
      dataA = 32'd7;
      dataB = 32'd2;
      @(negedge clk);
      start = 1'b0;
      repeat (W + 8) @(negedge clk);
      wait_idle();

      // Reset mid-run aborts with no pulse
      @(negedge clk);
      start = 1'b1;
      dataA = 32'd100;
      dataB = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      reset = 1'b1;
      #1;
      check("abort_done", W'(done), '0);
      check("abort_result", result, '0);
      @(negedge clk);
      reset = 1'b0;
      repeat (W + 8) @(negedge clk);
      run_op(32'd50, 32'd6, 0, 0);

      // Randomized operations
      for (int i = 0; i < 30; i++) begin
         a    = $urandom;
         mode = $urandom_range(0, 7);
         case (mode)
            0:       b = '0;
            1, 2:    b = W'($urandom_range(1, 20));
            3:       b = $urandom | 32'h8000_0000;
            4:       begin a = W'($urandom_range(0, 999)); b = W'($urandom_range(1000, 5000)); end
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 1) == 1) begin
            s_len = $urandom_range(1, 4);
            s_at  = $urandom_range(1, latency(b));
         end else begin
            s_len = 0;
            s_at  = 0;
         end
         run_op(a, b, s_at, s_len);
      end

      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_random_range
